// File: rtl/round_ne_stage_pkg.sv
// Shared types for the rounding stage of the floating-point/posit adder datapath.
// Rounding mode is carried per beat alongside the aligned mantissa.
package round_ne_stage_pkg;

    typedef enum logic {
        RND_RNE = 1'b0,
        RND_RTZ = 1'b1
    } round_mode_t;

endpackage

// File: rtl/round_ne_stage.sv
// Two-stage valid/ready rounding stage: S1 decides the round-up and adds it,
// S2 renormalises on carry-out and saturates when the exponent would overflow.
module round_ne_stage
    import round_ne_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned EXP_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] mant_i,
    input  logic                  guard_i,
    input  logic                  sticky_i,
    input  logic [EXP_WIDTH-1:0]  exp_i,
    input  logic                  rnd_mode_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] mant_o,
    output logic [EXP_WIDTH-1:0]  exp_o,
    output logic                  inexact_o,
    output logic                  ovf_o
);

    function automatic logic round_up_f(input logic [DATA_WIDTH-1:0] mant,
                                        input logic guard,
                                        input logic sticky,
                                        input round_mode_t mode);
        return (mode == RND_RNE) ? (guard & (sticky | mant[0])) : 1'b0;
    endfunction

    logic                  s1_valid_q;
    logic [DATA_WIDTH:0]   s1_sum_q;
    logic [EXP_WIDTH-1:0]  s1_exp_q;
    logic                  s1_inexact_q;

    logic                  s2_valid_q;
    logic [DATA_WIDTH-1:0] s2_mant_q;
    logic [EXP_WIDTH-1:0]  s2_exp_q;
    logic                  s2_inexact_q;
    logic                  s2_ovf_q;

    logic                  s1_adv;
    logic                  s2_adv;
    logic                  in_fire;
    logic                  round_up;
    logic [DATA_WIDTH:0]   sum_d;
    logic [DATA_WIDTH-1:0] mant_d;
    logic [EXP_WIDTH-1:0]  exp_d;
    logic                  ovf_d;

    assign s2_adv     = !s2_valid_q | out_ready_i;
    assign s1_adv     = !s1_valid_q | s2_adv;
    assign in_ready_o = s1_adv;
    assign in_fire    = in_valid_i & s1_adv;

    always_comb begin
        round_up = round_up_f(mant_i, guard_i, sticky_i, round_mode_t'(rnd_mode_i));
        sum_d    = {1'b0, mant_i} + {{DATA_WIDTH{1'b0}}, round_up};
    end

    // Carry-out only happens for an all-ones mantissa, so the result is exactly 1.0.
    always_comb begin
        mant_d = s1_sum_q[DATA_WIDTH-1:0];
        exp_d  = s1_exp_q;
        ovf_d  = 1'b0;
        if (s1_sum_q[DATA_WIDTH]) begin
            if (s1_exp_q == {EXP_WIDTH{1'b1}}) begin
                mant_d = {DATA_WIDTH{1'b1}};
                exp_d  = {EXP_WIDTH{1'b1}};
                ovf_d  = 1'b1;
            end else begin
                mant_d = {1'b1, {(DATA_WIDTH-1){1'b0}}};
                exp_d  = s1_exp_q + EXP_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_sum_q     <= '0;
            s1_exp_q     <= '0;
            s1_inexact_q <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid_i;
            end
            if (in_fire) begin
                s1_sum_q     <= sum_d;
                s1_exp_q     <= exp_i;
                s1_inexact_q <= guard_i | sticky_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q   <= 1'b0;
            s2_mant_q    <= '0;
            s2_exp_q     <= '0;
            s2_inexact_q <= 1'b0;
            s2_ovf_q     <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
            end
            if (s2_adv && s1_valid_q) begin
                s2_mant_q    <= mant_d;
                s2_exp_q     <= exp_d;
                s2_inexact_q <= s1_inexact_q;
                s2_ovf_q     <= ovf_d;
            end
        end
    end

    assign out_valid_o = s2_valid_q;
    assign mant_o      = s2_mant_q;
    assign exp_o       = s2_exp_q;
    assign inexact_o   = s2_inexact_q;
    assign ovf_o       = s2_ovf_q;

endmodule
